// File: rtl/axi4_rd_rr_arbiter2.sv
// Two-requester AXI4 read arbiter. AR requests are granted round-robin into a registered AR stage.
// R beats are routed back by the requester index held in the RID MSB.
module axi4_rd_rr_arbiter2 #(
    parameter int IDSIZE  = 4,
    parameter int ASIZE   = 32,
    parameter int LSIZE   = 8,
    parameter int DSIZE   = 256,
    parameter int MAX_OUT = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    // requester 0
    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ASIZE-1:0]  s0_araddr,
    input  logic [LSIZE-1:0]  s0_arlen,
    input  logic [IDSIZE-1:0] s0_arid,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DSIZE-1:0]  s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic [IDSIZE-1:0] s0_rid,
    // requester 1
    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ASIZE-1:0]  s1_araddr,
    input  logic [LSIZE-1:0]  s1_arlen,
    input  logic [IDSIZE-1:0] s1_arid,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DSIZE-1:0]  s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic [IDSIZE-1:0] s1_rid,
    // shared master port
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ASIZE-1:0]  m_araddr,
    output logic [LSIZE-1:0]  m_arlen,
    output logic [IDSIZE:0]   m_arid,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DSIZE-1:0]  m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic [IDSIZE:0]   m_rid,
    output logic [7:0]        outstanding
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

    typedef enum logic {IDLE, BUSY} ar_state_t;

    ar_state_t state, state_nxt;
    logic      rr_ptr, rr_ptr_nxt;
    logic      winner;
    logic      grant_ok;
    logic      ar_hs;
    logic      r_done;
    logic      r_sel;

    assign ar_hs  = m_arvalid & m_arready;
    assign r_done = m_rvalid & m_rready & m_rlast;

    // The pointed-to requester wins when it is asking, otherwise the other one does.
    assign winner   = (rr_ptr ? s1_arvalid : s0_arvalid) ? rr_ptr : ~rr_ptr;
    assign grant_ok = (state == IDLE) && (outstanding < MAX_CNT) && (s0_arvalid | s1_arvalid);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    s0_arready = ~winner;
                    s1_arready = winner;
                    rr_ptr_nxt = ~winner;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (m_arready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered AR stage, held stable until the master accepts it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arid    <= '0;
        end else if (grant_ok) begin
            m_arvalid <= 1'b1;
            m_araddr  <= winner ? s1_araddr : s0_araddr;
            m_arlen   <= winner ? s1_arlen  : s0_arlen;
            m_arid    <= {winner, (winner ? s1_arid : s0_arid)};
        end else if (ar_hs) begin
            m_arvalid <= 1'b0;
        end
    end

    // In-flight burst count; an RLAST with nothing outstanding is ignored.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 8'd0;
        end else if (ar_hs && !r_done) begin
            if (outstanding != MAX_CNT) outstanding <= outstanding + 8'd1;
        end else if (r_done && !ar_hs) begin
            if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
        end
    end

    assign r_sel     = m_rid[IDSIZE];
    assign s0_rvalid = m_rvalid & ~r_sel;
    assign s1_rvalid = m_rvalid &  r_sel;
    assign m_rready  = r_sel ? s1_rready : s0_rready;

    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign s0_rid    = m_rid[IDSIZE-1:0];
    assign s1_rid    = m_rid[IDSIZE-1:0];

endmodule

// File: tb/tb_axi4_rd_rr_arbiter2.sv
// Bench for axi4_rd_rr_arbiter2: directed scenarios plus a randomized run against a
// rule-level model of the round-robin grant, AR hold, in-flight count and R routing.
module tb_axi4_rd_rr_arbiter2;
    localparam int IDSIZE  = 4;
    localparam int ASIZE   = 32;
    localparam int LSIZE   = 8;
    localparam int DSIZE   = 32;
    localparam int MAX_OUT = 2;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic              req_valid [2];
    logic [ASIZE-1:0]  req_addr  [2];
    logic [LSIZE-1:0]  req_len   [2];
    logic [IDSIZE-1:0] req_id    [2];
    logic              rready    [2];

    logic              s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
    logic [DSIZE-1:0]  s0_rdata, s1_rdata;
    logic [1:0]        s0_rresp, s1_rresp;
    logic [IDSIZE-1:0] s0_rid, s1_rid;

    logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [ASIZE-1:0]  m_araddr;
    logic [LSIZE-1:0]  m_arlen;
    logic [IDSIZE:0]   m_arid, m_rid;
    logic [DSIZE-1:0]  m_rdata;
    logic [1:0]        m_rresp;
    logic [7:0]        outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_rd_rr_arbiter2 #(.IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .rst_n(rst_n),
        .s0_arvalid(req_valid[0]), .s0_arready(s0_arready), .s0_araddr(req_addr[0]), .s0_arlen(req_len[0]),
        .s0_arid(req_id[0]), .s0_rvalid(s0_rvalid), .s0_rready(rready[0]), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rid(s0_rid),
        .s1_arvalid(req_valid[1]), .s1_arready(s1_arready), .s1_araddr(req_addr[1]), .s1_arlen(req_len[1]),
        .s1_arid(req_id[1]), .s1_rvalid(s1_rvalid), .s1_rready(rready[1]), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rid(s1_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rid(m_rid), .outstanding(outstanding)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = 1'b0;
            req_addr[r]  = '0;
            req_len[r]   = '0;
            req_id[r]    = '0;
            rready[r]    = 1'b0;
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rid     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({m_arvalid, m_araddr, m_arlen, m_arid} !== '0) begin
            n_fail++;
            $display("FAIL reset_ar: m_arvalid=%b addr=%h len=%h id=%h, expected all 0", m_arvalid, m_araddr, m_arlen, m_arid);
        end
        n_checks++;
        if (outstanding !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        n_checks++;
        if ({s1_arready, s0_arready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_arready: got %b expected 00", {s1_arready, s0_arready});
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [DSIZE-1:0] d;
        do_reset();
        m_arready = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h1000; req_len[0] = 8'd3; req_id[0] = 4'd2;
        @(negedge clock);
        n_checks++;
        if ({s1_arready, s0_arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: arready got %b expected 01", {s1_arready, s0_arready});
        end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clock);
        n_checks++;
        if (m_arvalid !== 1'b1 || m_arid !== 5'h02 || m_araddr !== 32'h1000 || m_arlen !== 8'd3 || outstanding !== 8'd0) begin
            n_fail++;
            $display("FAIL single_ar: v=%b id=%h addr=%h len=%0d out=%0d expected 1/02/1000/3/0",
                     m_arvalid, m_arid, m_araddr, m_arlen, outstanding);
        end
        tick();
        m_arready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (m_arvalid !== 1'b0 || outstanding !== 8'd1) begin
            n_fail++;
            $display("FAIL single_after_hs: v=%b out=%0d expected 0/1", m_arvalid, outstanding);
        end
        tick();
        rready[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            m_rvalid = 1'b1; m_rid = 5'h02; m_rdata = d; m_rlast = (b == 3);
            @(negedge clock);
            n_checks++;
            if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || s0_rlast !== (b == 3) || s0_rdata !== d || m_rready !== 1'b1 || s0_rid !== 4'd2) begin
                n_fail++;
                $display("FAIL single_beat%0d: rv0=%b rv1=%b last=%b data=%h rready=%b rid=%h expected 1/0/%b/%h/1/2",
                         b, s0_rvalid, s1_rvalid, s0_rlast, s0_rdata, m_rready, s0_rid, (b == 3), d);
            end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outstanding !== 8'd0) begin
            n_fail++;
            $display("FAIL single_drain: outstanding got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int msb[$];
        logic [IDSIZE:0] q[$];
        do_reset();
        m_arready = 1'b1;
        rready[0] = 1'b1; rready[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = 1'b1; req_addr[r] = 32'h2000 + 32'(r * 16'h100); req_len[r] = '0; req_id[r] = IDSIZE'(r + 5);
        end
        for (int c = 0; c < 40 && msb.size() < 4; c++) begin
            if (q.size() > 0) begin
                m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = q[0];
            end else begin
                m_rvalid = 1'b0; m_rlast = 1'b0;
            end
            @(negedge clock);
            if (s0_arready) order.push_back(0);
            if (s1_arready) order.push_back(1);
            if (m_rvalid && m_rready) void'(q.pop_front());
            if (m_arvalid && m_arready) begin
                msb.push_back(int'(m_arid[IDSIZE]));
                q.push_back(m_arid);
            end
            tick();
        end
        req_valid[0] = 1'b0; req_valid[1] = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        n_checks++;
        if (msb.size() < 4 || order.size() < 4) begin
            n_fail++;
            $display("FAIL contention_timeout: grants=%0d handshakes=%0d expected 4", order.size(), msb.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != (i % 2) || msb[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL contention_order%0d: grant=%0d arid_msb=%0d expected %0d", i, order[i], msb[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid[1] = 1'b1; req_addr[1] = 32'hABCD0040; req_len[1] = 8'd7; req_id[1] = 4'd9;
        @(negedge clock);
        n_checks++;
        if ({s1_arready, s0_arready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_grant: arready got %b expected 10", {s1_arready, s0_arready});
        end
        tick();
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h5555; req_len[0] = 8'd1; req_id[0] = 4'd1;
        req_addr[1] = 32'hFFFF_FFFF; req_len[1] = 8'hFF; req_id[1] = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if (m_arvalid !== 1'b1 || m_araddr !== 32'hABCD0040 || m_arlen !== 8'd7 || m_arid !== 5'h19 ||
                {s1_arready, s0_arready} !== 2'b00 || outstanding !== 8'd0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b addr=%h len=%0d id=%h rdy=%b out=%0d expected 1/abcd0040/7/19/00/0",
                         c, m_arvalid, m_araddr, m_arlen, m_arid, {s1_arready, s0_arready}, outstanding);
            end
            tick();
        end
        m_arready = 1'b1;
        @(negedge clock);
        tick();
        m_arready = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clock);
        n_checks++;
        if (m_arvalid !== 1'b0 || outstanding !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_single_hs: v=%b out=%0d expected 0/1", m_arvalid, outstanding);
        end
    endtask

    task automatic test_throttle();
        int grants = 0;
        int hs = 0;
        do_reset();
        m_arready = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h3000; req_len[0] = '0; req_id[0] = 4'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (s0_arready) grants++;
            if (m_arvalid && m_arready) hs++;
            tick();
            req_id[0] = IDSIZE'(grants);
        end
        n_checks++;
        if (hs != 2 || grants != 2 || outstanding !== 8'd2) begin
            n_fail++;
            $display("FAIL throttle_limit: handshakes=%0d grants=%0d out=%0d expected 2/2/2", hs, grants, outstanding);
        end
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h00; rready[0] = 1'b1;
        @(negedge clock);
        n_checks++;
        if (s0_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL throttle_blocked: s0_arready got %b expected 0", s0_arready);
        end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outstanding !== 8'd1 || s0_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL throttle_release: out=%0d s0_arready=%b expected 1/1", outstanding, s0_arready);
        end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_checks++;
        if (outstanding !== 8'd2) begin
            n_fail++;
            $display("FAIL throttle_third: outstanding got %0d expected 2", outstanding);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        m_arready = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h4000; req_len[0] = '0; req_id[0] = 4'd1;
        @(negedge clock);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clock);
        tick();
        m_arready = 1'b0;
        req_valid[0] = 1'b1; req_id[0] = 4'd2;
        @(negedge clock);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clock);
        n_checks++;
        if (m_arvalid !== 1'b1 || outstanding !== 8'd1) begin
            n_fail++;
            $display("FAIL simul_setup: v=%b out=%0d expected 1/1", m_arvalid, outstanding);
        end
        m_arready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h01; rready[0] = 1'b1;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outstanding !== 8'd1 || m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_count: out=%0d v=%b expected 1/0", outstanding, m_arvalid);
        end
    endtask

    task automatic test_rbp_reset();
        logic [DSIZE-1:0] d;
        do_reset();
        m_arready = 1'b1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h6000; req_len[1] = 8'd1; req_id[1] = 4'd3;
        @(negedge clock);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clock);
        tick();
        m_arready = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h7000; req_len[0] = 8'd2; req_id[0] = 4'd4;
        @(negedge clock);
        tick();
        req_valid[0] = 1'b0;
        d = $urandom;
        m_rvalid = 1'b1; m_rid = 5'h13; m_rdata = d; m_rlast = 1'b0; rready[1] = 1'b0; rready[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (m_rready !== 1'b0 || s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_rdata !== d || s1_rid !== 4'd3) begin
                n_fail++;
                $display("FAIL rbp_hold%0d: m_rready=%b rv1=%b rv0=%b data=%h rid=%h expected 0/1/0/%h/3",
                         c, m_rready, s1_rvalid, s0_rvalid, s1_rdata, s1_rid, d);
            end
            tick();
        end
        @(negedge clock);
        n_checks++;
        if (m_arvalid !== 1'b1 || outstanding !== 8'd1) begin
            n_fail++;
            $display("FAIL rbp_pre_reset: v=%b out=%0d expected 1/1", m_arvalid, outstanding);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_arvalid !== 1'b0 || outstanding !== 8'd0 || m_arid !== '0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b out=%0d id=%h expected 0/0/00", m_arvalid, outstanding, m_arid);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit               pending = 1'b0;
        bit               ptr = 1'b0;
        bit               granted [2];
        bit               r_hs = 1'b1;
        bit               allowed, win, ar_hs, r_done, sel;
        int               cnt = 0;
        int               beat = 0;
        logic [1:0]       exp_rdy;
        logic [ASIZE-1:0] e_addr = '0;
        logic [LSIZE-1:0] e_len = '0;
        logic [IDSIZE:0]  e_id = '0;
        logic [IDSIZE:0]  q_id[$];
        logic [LSIZE-1:0] q_len[$];
        granted[0] = 1'b0; granted[1] = 1'b0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (granted[r] || !req_valid[r]) begin
                    req_valid[r] = ($urandom_range(0, 1) == 1);
                    req_addr[r]  = $urandom;
                    req_len[r]   = LSIZE'($urandom_range(0, 3));
                    req_id[r]    = IDSIZE'($urandom);
                end
                granted[r] = 1'b0;
                rready[r]  = ($urandom_range(0, 3) != 0);
            end
            m_arready = ($urandom_range(0, 2) != 0);
            if (!(m_rvalid && !r_hs)) begin
                if (q_id.size() > 0 && $urandom_range(0, 3) != 0) begin
                    m_rvalid = 1'b1;
                    m_rid    = q_id[0];
                    m_rlast  = (beat == int'(q_len[0]));
                    m_rdata  = $urandom;
                    m_rresp  = 2'($urandom);
                end else begin
                    m_rvalid = 1'b0;
                    m_rlast  = 1'b0;
                end
            end
            @(negedge clock);
            allowed = !pending && (cnt < MAX_OUT) && (req_valid[0] || req_valid[1]);
            win     = ptr ? (req_valid[1] ? 1'b1 : 1'b0) : (req_valid[0] ? 1'b0 : 1'b1);
            exp_rdy = allowed ? (win ? 2'b10 : 2'b01) : 2'b00;
            n_checks++;
            if ({s1_arready, s0_arready} !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_arready c%0d: got %b expected %b", c, {s1_arready, s0_arready}, exp_rdy);
            end
            n_checks++;
            if (pending ? (m_arvalid !== 1'b1 || m_araddr !== e_addr || m_arlen !== e_len || m_arid !== e_id)
                        : (m_arvalid !== 1'b0)) begin
                n_fail++;
                $display("FAIL rand_ar c%0d: v=%b addr=%h len=%0d id=%h expected v=%b addr=%h len=%0d id=%h",
                         c, m_arvalid, m_araddr, m_arlen, m_arid, pending, e_addr, e_len, e_id);
            end
            n_checks++;
            if (outstanding !== 8'(cnt)) begin
                n_fail++;
                $display("FAIL rand_outstanding c%0d: got %0d expected %0d", c, outstanding, cnt);
            end
            sel = m_rid[IDSIZE];
            n_checks++;
            if ({s1_rvalid, s0_rvalid} !== (m_rvalid ? (sel ? 2'b10 : 2'b01) : 2'b00) ||
                (m_rvalid && m_rready !== rready[sel]) ||
                s0_rdata !== m_rdata || s1_rdata !== m_rdata || s0_rresp !== m_rresp || s1_rresp !== m_rresp ||
                s0_rlast !== m_rlast || s1_rlast !== m_rlast ||
                s0_rid !== m_rid[IDSIZE-1:0] || s1_rid !== m_rid[IDSIZE-1:0]) begin
                n_fail++;
                $display("FAIL rand_route c%0d: rvalid=%b m_rready=%b rid=%h expected rvalid for sel=%b rready=%b",
                         c, {s1_rvalid, s0_rvalid}, m_rready, m_rid, sel, rready[sel]);
            end
            r_hs   = m_rvalid && rready[sel];
            r_done = r_hs && m_rlast;
            if (r_hs) begin
                if (m_rlast) begin
                    void'(q_id.pop_front());
                    void'(q_len.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            ar_hs = pending && m_arready;
            if (ar_hs) begin
                q_id.push_back(e_id);
                q_len.push_back(e_len);
                pending = 1'b0;
            end
            if (ar_hs && !r_done && cnt < MAX_OUT) cnt++;
            else if (r_done && !ar_hs && cnt > 0) cnt--;
            if (allowed) begin
                pending = 1'b1;
                e_addr  = req_addr[win];
                e_len   = req_len[win];
                e_id    = {win, req_id[win]};
                ptr     = !win;
                granted[win] = 1'b1;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_throttle();
        test_simultaneous();
        test_rbp_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_rd_rr_arbiter2.md
Name: axi4_rd_rr_arbiter2

Overview:
Shares one AXI4 read channel (AR + R) between two read requesters, for example two burst-partitioning front ends feeding a single DDR read port. Address requests are granted round-robin into a registered AR stage. The grant index is carried as the MSB of the master ARID, and the returned R beats are routed back by RID MSB. An outstanding-burst counter throttles new grants.

Parameters:
IDSIZE, 4, requester ARID/RID width; master ID width is IDSIZE+1
ASIZE, 32, address width
LSIZE, 8, ARLEN width
DSIZE, 256, RDATA width
MAX_OUT, 8, maximum master bursts in flight (AR accepted, RLAST not yet accepted); 1..255

Ports:
clock  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s0_arvalid  in  1  requester 0 AR valid
s0_arready  out  1  requester 0 AR ready
s0_araddr  in  ASIZE  requester 0 address
s0_arlen  in  LSIZE  requester 0 burst length-1
s0_arid  in  IDSIZE  requester 0 ID
s0_rvalid  out  1  requester 0 R valid
s0_rready  in  1  requester 0 R ready
s0_rdata  out  DSIZE  requester 0 read data
s0_rresp  out  2  requester 0 response
s0_rlast  out  1  requester 0 last beat
s0_rid  out  IDSIZE  requester 0 RID
s1_*  (same 11 signals, same directions and widths)  requester 1
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_araddr  out  ASIZE  master address
m_arlen  out  LSIZE  master length
m_arid  out  IDSIZE+1  master ID, {grant_idx, s_arid}
m_rvalid  in  1  master R valid
m_rready  out  1  master R ready
m_rdata  in  DSIZE  master read data
m_rresp  in  2  master response
m_rlast  in  1  master last beat
m_rid  in  IDSIZE+1  master RID
outstanding  out  8  current in-flight burst count

Behaviour:
- Reset: m_arvalid=0; m_araddr, m_arlen, m_arid=0; outstanding=0; round-robin pointer=0 (requester 0 has priority); s0_arready=s1_arready=0.
- AR state machine:
  - IDLE: grant is allowed when outstanding < MAX_OUT and at least one sN_arvalid is high.
  - Winner selection: the requester pointed to wins if its arvalid is high, else the other requester wins.
  - On grant: the winner's sN_arready pulses combinationally for one cycle (the handshake is in cycle N). The AR fields and m_arid={idx, arid} are registered, and m_arvalid=1 in cycle N+1. The pointer moves to the other requester. Next state is BUSY.
  - BUSY: m_arvalid and all AR fields are held stable until m_arready. In the handshake cycle, the state returns to IDLE. A new grant is issued no earlier than the cycle after the handshake (one bubble per burst is accepted).
  - Both sN_arready are 0 in BUSY and whenever outstanding == MAX_OUT.
- Outstanding counter:
  - +1 on the m_ar handshake.
  - -1 on m_rvalid & m_rready & m_rlast.
  - Both events in the same cycle: count unchanged.
  - The count never exceeds MAX_OUT and never underflows. An RLAST arriving at count 0 is a protocol error: the count stays 0.
  - The limit check uses the registered count. Because one BUSY cycle separates grants, the limit cannot be exceeded.
- R routing (combinational, zero latency):
  - sel = m_rid[IDSIZE].
  - s_sel_rvalid = m_rvalid; the other requester's rvalid = 0.
  - m_rready = sel ? s1_rready : s0_rready.
  - rdata, rresp, rlast and rid=m_rid[IDSIZE-1:0] are broadcast to both requesters and qualified only by rvalid.
- Reset mid-operation: all state clears immediately. In-flight bursts are dropped and the counter returns to 0.

Test Plan:
- Single request: s0 AR addr=0x1000, len=3, id=2 with m_arready=1 → s0_arready pulses at cycle N, m_arvalid=1 at N+1 with m_arid=0x02. After 4 beats with RID=0x02, s0 receives 4 beats, rlast on beat 4, s1_rvalid stays 0, outstanding goes 0→1→0.
- Contention: s0 and s1 both hold arvalid for 4 grants → grant order is 0,1,0,1 and m_arid MSB alternates 0,1,0,1.
- Backpressure: m_arready=0 for 5 cycles after m_arvalid → AR fields stay stable, both arready stay 0, then a single handshake occurs.
- Throttle: MAX_OUT=2, no R returns, 3 requests → 2 handshakes, then arready=0. One RLAST restores count 1, and the third grant follows.
- Simultaneous events: m_ar handshake in the same cycle as RLAST with count=1 → count stays 1.
- R backpressure and reset: RID MSB=1 with s1_rready=0 → m_rready=0 and the data is held. Asserting rst_n=0 mid-burst → m_arvalid=0 and outstanding=0 immediately.
